// File: rtl/j1_pkg.sv
// Shared J1 constants and the fetch FIFO payload layout.
// fetch_entry_t is the default-width view of what insn_fetch buffers.
package j1_pkg;

  localparam int unsigned INSN_WIDTH = 16;
  localparam int unsigned ROM_SIZE   = 'h1000;
  localparam int unsigned PC_WIDTH   = $clog2(ROM_SIZE);

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INSN_WIDTH-1:0] insn;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a synchronous flush and an occupancy count.
// The head word is presented combinationally from storage.
module fetch_fifo #(
  parameter  int unsigned depth = 2,
  parameter  int unsigned width = 28,
  localparam int unsigned cnt_w = $clog2(depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [width-1:0] data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic [cnt_w-1:0] count
);

  localparam int unsigned ptr_w = (depth > 1) ? $clog2(depth) : 1;

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] rd_ptr;
  logic [ptr_w-1:0] wr_ptr;

  // Pointer advance with wrap at depth, so non-power-of-two depths work.
  function automatic logic [ptr_w-1:0] bump(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(depth); i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= bump(wr_ptr);
      end
      if (pop) rd_ptr <= bump(rd_ptr);
      count <= count + cnt_w'(push) - cnt_w'(pop);
    end
  end

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch: drives the ROM, absorbs its one-cycle latency through a
// single in-flight tag, buffers words in fetch_fifo and handles redirects.
module insn_fetch
  import j1_pkg::*;
#(
  parameter int unsigned           addr_width = PC_WIDTH,
  parameter int unsigned           data_width = INSN_WIDTH,
  parameter int unsigned           depth      = 2,
  parameter logic [addr_width-1:0] reset_pc   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [addr_width-1:0] rom_address,
  output logic                  rom_cen,
  input  logic [data_width-1:0] rom_q,
  input  logic                  redirect,
  input  logic [addr_width-1:0] redirect_pc,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [data_width-1:0] insn,
  output logic [addr_width-1:0] insn_pc
);

  localparam int unsigned cnt_w = $clog2(depth + 1);
  localparam int unsigned occ_w = cnt_w + 1;

  typedef struct packed {
    logic [addr_width-1:0] pc;
    logic [data_width-1:0] word;
  } entry_t;

  logic [addr_width-1:0] pc;
  logic [addr_width-1:0] pend_pc;
  logic                  pend;
  logic [cnt_w-1:0]      count;
  logic [occ_w-1:0]      occ;
  logic                  pop;
  logic                  push;
  logic                  issue;
  entry_t                push_entry;
  entry_t                head_entry;

  assign insn_valid = (count != '0);
  assign pop        = insn_valid & insn_ready;

  // Slots committed after this cycle; a same-cycle pop frees one immediately.
  assign occ   = occ_w'(count) + occ_w'(pend) - occ_w'(pop);
  assign issue = occ < occ_w'(depth);

  // A redirect discards the word returning for the old stream.
  assign push       = pend & ~redirect;
  assign push_entry = '{pc: pend_pc, word: rom_q};

  assign insn    = head_entry.word;
  assign insn_pc = head_entry.pc;

  // ROM request; held off while reset is asserted.
  always_comb begin
    rom_address = pc;
    rom_cen     = 1'b0;
    if (reset_n) begin
      if (redirect) begin
        rom_address = redirect_pc;
        rom_cen     = 1'b1;
      end else begin
        rom_cen = issue;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= reset_pc;
      pend    <= 1'b0;
      pend_pc <= '0;
    end else if (redirect) begin
      pc      <= redirect_pc + addr_width'(1);
      pend    <= 1'b1;
      pend_pc <= redirect_pc;
    end else if (issue) begin
      pc      <= pc + addr_width'(1);
      pend    <= 1'b1;
      pend_pc <= pc;
    end else begin
      pend <= 1'b0;
    end
  end

  fetch_fifo #(
    .depth (depth),
    .width ($bits(entry_t))
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset_n),
    .flush (redirect),
    .push  (push),
    .data  (push_entry),
    .pop   (pop),
    .head  (head_entry),
    .count (count)
  );

endmodule
